// File: rtl/atan_arbiter_if.sv
// Requester and result handshake bundle for atan_arbiter.
// The arbiter takes the master modport; the requesters and the result consumer take the slave modport.
interface atan_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = $clog2(N_REQ),
    parameter int DATA_W = 16
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W*N_REQ-1:0] req_x;
    logic [DATA_W*N_REQ-1:0] req_y;
    logic                    res_valid;
    logic                    res_ready;
    logic [TAG_W-1:0]        res_tag;
    logic [7:0]              res_angle;

    modport master (
        input  req_valid, req_x, req_y, res_ready,
        output req_ready, res_valid, res_tag, res_angle
    );

    modport slave (
        output req_valid, req_x, req_y, res_ready,
        input  req_ready, res_valid, res_tag, res_angle
    );
endinterface

// File: rtl/atan_arbiter.sv
// Round-robin sharing of one 3-stage atan_lut pipeline between N_REQ requesters.
// A tag/valid shadow of the pipeline routes each angle back to its requester.
module atan_arbiter #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = $clog2(N_REQ),
    parameter int LAT    = 3,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    atan_arbiter_if.master           bus,
    output logic                     atan_ready,
    output logic signed [DATA_W-1:0] atan_x,
    output logic signed [DATA_W-1:0] atan_y,
    input  logic [7:0]               atan_angle,
    output logic [1:0]               in_flight,
    output logic                     idle
);

    logic             vld_p0, vld_p1, vld_p2;
    logic [TAG_W-1:0] tag_p0, tag_p1, tag_p2;
    logic [TAG_W-1:0] rr_ptr;
    logic             adv;
    logic             found;
    logic             grant;
    logic [TAG_W-1:0] g;
    logic [TAG_W-1:0] idx;
    logic [LAT-1:0]   vld_all;

    function automatic logic [1:0] count_valid(input logic [LAT-1:0] v);
        logic [1:0] n;
        n = '0;
        for (int i = 0; i < LAT; i++) begin
            n = n + 2'(v[i]);
        end
        return n;
    endfunction

    // The whole pipeline freezes while a result waits, so nothing upstream can be lost.
    assign adv        = !vld_p2 || bus.res_ready;
    assign atan_ready = adv && resetn;

    // Scanning downwards lets the entry closest to rr_ptr win the last assignment.
    always_comb begin
        found = 1'b0;
        g     = '0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (int'(rr_ptr) + k >= N_REQ) begin
                idx = TAG_W'(int'(rr_ptr) + k - N_REQ);
            end else begin
                idx = TAG_W'(int'(rr_ptr) + k);
            end
            if (bus.req_valid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
    end

    assign grant = found && atan_ready;

    always_comb begin
        bus.req_ready = '0;
        atan_x        = '0;
        atan_y        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant && (g == TAG_W'(i))) begin
                bus.req_ready[i] = 1'b1;
                atan_x           = $signed(bus.req_x[i*DATA_W +: DATA_W]);
                atan_y           = $signed(bus.req_y[i*DATA_W +: DATA_W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            tag_p0 <= '0;
            tag_p1 <= '0;
            tag_p2 <= '0;
            rr_ptr <= '0;
        end else if (adv) begin
            // p0: operand captured by the pipeline
            vld_p0 <= grant;
            tag_p0 <= g;
            // p1: middle stage
            vld_p1 <= vld_p0;
            tag_p1 <= tag_p0;
            // p2: angle presented on the result port
            vld_p2 <= vld_p1;
            tag_p2 <= tag_p1;
            if (grant) begin
                rr_ptr <= (g == TAG_W'(N_REQ - 1)) ? '0 : g + 1'b1;
            end
        end
    end

    assign bus.res_valid = vld_p2;
    assign bus.res_tag   = tag_p2;
    assign bus.res_angle = atan_angle;

    assign vld_all   = {vld_p2, vld_p1, vld_p0};
    assign in_flight = count_valid(vld_all);
    assign idle      = (in_flight == 2'd0) && !(|bus.req_valid);

endmodule

// File: tb/tb_atan_arbiter.sv
// Bench for atan_arbiter: a stub angle pipeline, a token-queue reference model and directed plus random steps.
module tb_atan_arbiter;
    localparam int N  = 4;
    localparam int TW = 2;

    logic               clk = 1'b0;
    logic               resetn;
    logic               atan_ready;
    logic signed [15:0] atan_x, atan_y;
    logic [7:0]         atan_angle;
    logic [1:0]         in_flight;
    logic               idle;

    always #5 clk = ~clk;

    atan_arbiter_if #(.N_REQ(N)) bus ();

    atan_arbiter #(.N_REQ(N)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .atan_ready (atan_ready),
        .atan_x     (atan_x),
        .atan_y     (atan_y),
        .atan_angle (atan_angle),
        .in_flight  (in_flight),
        .idle       (idle)
    );

    function automatic logic [7:0] ref_angle(input int x, input int y);
        real a;
        int  v;
        a = $atan2(real'(y), real'(x));
        v = int'($floor(a * 128.0 / 3.14159265358979 + 0.5));
        return 8'(v & 255);
    endfunction

    // Stand-in for the external 3-stage atan_lut, advancing only on atan_ready.
    logic [7:0] lut_s0, lut_s1, lut_s2;
    always_ff @(posedge clk) begin
        if (atan_ready) begin
            lut_s0 <= ref_angle(atan_x, atan_y);
            lut_s1 <= lut_s0;
            lut_s2 <= lut_s1;
        end
    end
    assign atan_angle = lut_s2;

    typedef struct {
        int tag;
        int angle;
        int issue;
    } tok_t;

    tok_t q[$];
    int   adv_cnt = 0;
    int   ptr = 0;
    int   checks = 0;
    int   errors = 0;
    bit   pend_v [N];
    int   pend_x [N];
    int   pend_y [N];
    bit   sticky [N];
    bit   random_refill = 1'b0;
    int   log_grant[$];
    int   log_tag[$];
    int   log_ang[$];
    int   log_if[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_seq(input string tag, input int got[$], input int exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) chk(tag, got[i], exp[i]);
            else                chk(tag, -1, exp[i]);
        end
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic set_req(input int i, input int x, input int y);
        pend_v[i] = 1'b1;
        pend_x[i] = x;
        pend_y[i] = y;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            pend_v[i] = 1'b0;
            sticky[i] = 1'b0;
        end
    endtask

    task automatic clear_logs();
        log_grant.delete();
        log_tag.delete();
        log_ang.delete();
        log_if.delete();
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]         = pend_v[i];
            bus.req_x[16*i +: 16]    = 16'(pend_x[i]);
            bus.req_y[16*i +: 16]    = 16'(pend_y[i]);
        end
    endtask

    // One clock: drive, predict, compare, step the model across the edge.
    task automatic cycle();
        int         g;
        bit         exp_valid;
        bit         exp_adv;
        bit         any_req;
        logic [N-1:0] exp_rdy;
        apply();
        #1;
        exp_valid = (q.size() > 0) && (adv_cnt - q[0].issue == 3);
        exp_adv   = resetn && (!exp_valid || bus.res_ready);
        any_req   = 1'b0;
        for (int i = 0; i < N; i++) any_req |= pend_v[i];
        g = -1;
        if (exp_adv) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pend_v[(ptr + k) % N]) g = (ptr + k) % N;
            end
        end
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        chk("atan_ready", atan_ready, exp_adv);
        chk("req_ready", bus.req_ready, exp_rdy);
        chk("atan_x", 32'(int'(atan_x)), (g >= 0) ? pend_x[g] : 0);
        chk("atan_y", 32'(int'(atan_y)), (g >= 0) ? pend_y[g] : 0);
        if (resetn) begin
            chk("res_valid", bus.res_valid, exp_valid);
            chk("in_flight", in_flight, q.size());
            chk("idle", idle, (q.size() == 0) && !any_req);
            if (exp_valid) begin
                chk("res_tag", bus.res_tag, q[0].tag);
                chk("res_angle", bus.res_angle, q[0].angle);
            end
            log_if.push_back(int'(in_flight));
            for (int i = 0; i < N; i++) if (bus.req_ready[i]) log_grant.push_back(i);
            if (exp_valid && bus.res_ready) begin
                log_tag.push_back(int'(bus.res_tag));
                log_ang.push_back(int'(bus.res_angle));
            end
        end
        @(posedge clk);
        if (!resetn) begin
            q.delete();
            adv_cnt = 0;
            ptr     = 0;
        end else if (exp_adv) begin
            if (exp_valid) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back('{g, int'(ref_angle(pend_x[g], pend_y[g])), adv_cnt});
                ptr = (g + 1) % N;
                if (!sticky[g]) pend_v[g] = 1'b0;
            end
            adv_cnt++;
        end
        if (random_refill) begin
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && $urandom_range(0, 2) == 0) set_req(i, rnd16(), rnd16());
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int e[$];
        resetn        = 1'b0;
        bus.res_ready = 1'b1;
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        for (int i = 0; i < N; i++) begin
            pend_v[i] = 1'b0;
            pend_x[i] = 0;
            pend_y[i] = 0;
            sticky[i] = 1'b0;
        end
        @(negedge clk);
        run(2);
        resetn = 1'b1;
        #1;
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_tag", bus.res_tag, 0);
        chk("rst_in_flight", in_flight, 0);
        chk("rst_idle", idle, 1);

        // Single requester, full latency
        clear_logs();
        set_req(0, 1000, 0);
        run(5);
        e = '{0};           chk_seq("single_grant", log_grant, e);
        e = '{0};           chk_seq("single_tag", log_tag, e);
        e = '{0};           chk_seq("single_angle", log_ang, e);
        e = '{0, 1, 1, 1, 0}; chk_seq("single_in_flight", log_if, e);

        // Four requesters, four quadrants
        resetn = 1'b0;
        run(1);
        resetn = 1'b1;
        clear_logs();
        set_req(0, 1000, 0);
        set_req(1, 0, 1000);
        set_req(2, -1000, 0);
        set_req(3, 0, -1000);
        run(8);
        e = '{0, 1, 2, 3};       chk_seq("quad_grant", log_grant, e);
        e = '{0, 1, 2, 3};       chk_seq("quad_tag", log_tag, e);
        e = '{0, 64, 128, 192};  chk_seq("quad_angle", log_ang, e);

        // Requesters 1 and 3 held valid
        clear_logs();
        set_req(1, 500, 500);
        set_req(3, -500, 500);
        sticky[1] = 1'b1;
        sticky[3] = 1'b1;
        run(6);
        e = '{1, 3, 1, 3, 1, 3}; chk_seq("alt_grant", log_grant, e);
        clear_reqs();
        run(4);
        e = '{32, 96, 32};       chk_seq("alt_angle", log_ang, e);

        // Downstream stall in the middle of a stream
        for (int i = 0; i < N; i++) begin
            set_req(i, rnd16(), rnd16());
            sticky[i] = 1'b1;
        end
        run(4);
        bus.res_ready = 1'b0;
        run(5);
        bus.res_ready = 1'b1;
        run(4);
        clear_reqs();
        run(4);
        chk("stall_drained", in_flight, 0);

        // Reset with three tokens in flight
        for (int i = 0; i < N; i++) begin
            set_req(i, rnd16(), rnd16());
            sticky[i] = 1'b1;
        end
        run(4);
        chk("pre_reset_in_flight", in_flight, 3);
        clear_reqs();
        resetn = 1'b0;
        run(1);
        resetn = 1'b1;
        #1;
        chk("mid_rst_res_valid", bus.res_valid, 0);
        chk("mid_rst_in_flight", in_flight, 0);
        chk("mid_rst_idle", idle, 1);
        run(3);

        // Two tokens drain through bubbles
        clear_logs();
        set_req(3, 100, -100);
        set_req(2, -300, 300);
        run(2);
        e = '{2, 3};  chk_seq("post_rst_grant", log_grant, e);
        run(3);
        e = '{2, 3};  chk_seq("drain_tag", log_tag, e);
        e = '{96, 224}; chk_seq("drain_angle", log_ang, e);
        chk("drain_idle", idle, 1);

        // Random traffic with random backpressure
        random_refill = 1'b1;
        for (int i = 0; i < 600; i++) begin
            bus.res_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        random_refill = 1'b0;
        bus.res_ready = 1'b1;
        clear_reqs();
        run(6);
        chk("final_in_flight", in_flight, 0);
        chk("final_idle", idle, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/atan_arbiter.md
Name: atan_arbiter

Overview:
- Shares one 3-stage atan_lut angle pipeline between N_REQ requesters, such as per-channel I/Q sample sources.
- Arbitrates round-robin, drives the pipeline's x/y operands and its advance enable, and tags each issued operand.
- Returns each result with its requester tag on a single valid/ready result port.
- Downstream backpressure is handled by freezing the pipeline, so no skid buffer is needed.

Parameters:
- N_REQ, 4: number of requesters (2..16).
- TAG_W, $clog2(N_REQ): width of the result tag.
- LAT, 3: pipeline advances from operand capture to angle output. Fixed to match the atan_lut pipeline.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  per-requester accept; one-hot or zero
- req_x  in  16*N_REQ  signed x operands, requester i at [16i+15:16i]
- req_y  in  16*N_REQ  signed y operands, same packing as req_x
- res_valid  out  1  result valid
- res_ready  in  1  downstream accept
- res_tag  out  TAG_W  requester index of the current result
- res_angle  out  8  angle, 256 units per turn (0 = +x, 64 = +y)
- atan_ready  out  1  advance enable to the atan_lut pipeline
- atan_x  out  16  operand x to the pipeline
- atan_y  out  16  operand y to the pipeline
- atan_angle  in  8  registered angle output from the pipeline
- in_flight  out  2  number of valid tokens in the pipeline (0..3)
- idle  out  1  high when in_flight==0 and no req_valid is asserted

Behaviour:
- Clock and reset:
  - Single clock clk.
  - resetn is synchronous, active-low; the pipeline shares this resetn.
  - While resetn is low: atan_ready=0, req_ready=0, vld_sr=0, tag_sr=0, rr_ptr=0. This gives res_valid=0, res_tag=0, in_flight=0.
- Tracking state:
  - Shadow shift register vld_sr[0..2] and tag_sr[0..2] mirrors the pipeline stages.
  - Round-robin pointer rr_ptr, TAG_W bits.
- Advance rule (combinational): adv = !res_valid || res_ready.
  - atan_ready = adv.
  - Shadow registers shift only on clock edges where adv=1.
  - When adv=0, all state holds. The pipeline is frozen, so atan_angle is stable.
- Arbitration (combinational, only when adv=1):
  - g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_ready[g]=1; every other bit is 0.
  - atan_x = req_x[g], atan_y = req_y[g].
  - With no grant, atan_x and atan_y are 0.
- On an advance edge:
  - vld_sr[0] <= any grant; tag_sr[0] <= g.
  - vld_sr[k] <= vld_sr[k-1] and tag_sr[k] <= tag_sr[k-1].
  - On a grant, rr_ptr <= (g+1) mod N_REQ; otherwise rr_ptr holds.
  - Bubbles advance as invalid tokens, so the pipeline drains with no requests pending.
- Result port:
  - res_valid = vld_sr[2], res_tag = tag_sr[2], res_angle = atan_angle, all combinational from registers.
  - A result transfers on an edge where res_valid and res_ready are both high.
- Latency:
  - An operand accepted at edge k, with adv held high, yields res_valid=1 in the cycle after edge k+2 (the third advance).
  - Each cycle with adv=0 adds one cycle of latency.
  - Peak throughput is 1 result per cycle.
- Backpressure: while res_valid=1 and res_ready=0, no request is accepted and res_* holds stable, with no loss or duplication.
- Simultaneous accept and retire in the same edge is legal and is the normal streaming case.
- in_flight = popcount(vld_sr).
- Requester obligation: req_x, req_y and req_valid hold until req_ready. The arbiter does not check this.
- Reset mid-operation: all in-flight tokens are discarded and no result is emitted for them. The first grant after reset goes to the lowest valid index.

Test Plan:
- Single requester 0, (x=1000, y=0), res_ready=1 -> req_ready[0] for 1 cycle; res_valid after 3 advances with res_tag=0, res_angle=0; in_flight 1,1,1,0.
- Requesters 0..3 all valid with (1000,0), (0,1000), (-1000,0), (0,-1000), res_ready=1 -> grants in order 0,1,2,3; results back-to-back with tags 0,1,2,3 and angles 0,64,128,192; rr_ptr wraps to 0.
- Requesters 1 and 3 continuously valid -> grants alternate 1,3,1,3; requesters 0 and 2 are never granted; no requester is starved.
- res_ready low for 5 cycles mid-stream -> atan_ready=0, req_ready=0, res_tag and res_angle stable; on release the stream resumes with no gap, drop or duplicate; output order matches grant order.
- resetn low for 1 cycle with 3 tokens in flight -> the next cycle shows res_valid=0, in_flight=0, idle=1; no stale result appears afterwards; the next grant goes to the lowest valid index.
- No requests with 2 tokens in flight -> both drain via bubbles within 3 cycles; idle goes high the cycle after the last transfer.
